// File: rtl/dcache_pkg.sv
// Shared constants, FSM state type and metadata layout for the data-cache fill controller.
package dcache_pkg;

    localparam int unsigned MEM_LAT = 4;
    localparam int unsigned WORDS   = 8;
    localparam int unsigned SETS    = 64;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned SET_W   = 6;
    localparam int unsigned WORD_W  = 3;
    localparam int unsigned CNT_W   = 4;

    localparam int unsigned TAG_HI  = 15;
    localparam int unsigned TAG_LO  = 10;
    localparam int unsigned SET_HI  = 9;
    localparam int unsigned SET_LO  = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    typedef struct packed {
        logic             valid;
        logic             lru;
        logic [TAG_W-1:0] tag;
    } meta_t;

    // lru=1 in the freshly filled way points the next replacement at the other way.
    function automatic meta_t fill_meta(input logic [TAG_W-1:0] tag);
        meta_t m;
        m.valid = 1'b1;
        m.lru   = 1'b1;
        m.tag   = tag;
        return m;
    endfunction

endpackage

// File: rtl/dcache_fill_fsm_if.sv
// Miss, memory-read and cache-write signals between the fill controller and its surroundings.
interface dcache_fill_fsm_if;

    logic                          miss_detected;
    logic [dcache_pkg::ADDR_W-1:0] miss_address;
    logic                          victim_way;
    logic                          mem_data_valid;
    logic [dcache_pkg::DATA_W-1:0] mem_data;

    logic                          stall;
    logic                          mem_en;
    logic [dcache_pkg::ADDR_W-1:0] mem_addr;
    logic                          write_en_0;
    logic                          write_en_1;
    logic [dcache_pkg::DATA_W-1:0] cache_data;
    logic [dcache_pkg::WORDS-1:0]  cache_word;
    logic [dcache_pkg::SETS-1:0]   cache_block;
    logic [7:0]                    cache_tag;
    logic                          fill_done;

    modport master (
        input  miss_detected, miss_address, victim_way, mem_data_valid, mem_data,
        output stall, mem_en, mem_addr, write_en_0, write_en_1,
        output cache_data, cache_word, cache_block, cache_tag, fill_done
    );

    modport slave (
        output miss_detected, miss_address, victim_way, mem_data_valid, mem_data,
        input  stall, mem_en, mem_addr, write_en_0, write_en_1,
        input  cache_data, cache_word, cache_block, cache_tag, fill_done
    );

endinterface

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder, N select bits to 2**N outputs.
module onehot_dec #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]        sel_i,
    output logic [(1<<N)-1:0]   onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/dcache_fill_fsm.sv
// Cache miss fill controller: issues 8 pipelined word reads and installs returns in the victim way.
module dcache_fill_fsm
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dcache_fill_fsm_if.master bus
);

    fill_state_e        state_q, state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic               victim_q, victim_d;

    logic [WORDS-1:0]   word_oh;
    logic [SETS-1:0]    set_oh;

    onehot_dec #(.N(WORD_W)) u_word_dec (
        .sel_i    (ret_cnt_q[WORD_W-1:0]),
        .onehot_o (word_oh)
    );

    onehot_dec #(.N(SET_W)) u_set_dec (
        .sel_i    (set_q),
        .onehot_o (set_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            tag_q       <= '0;
            set_q       <= '0;
            victim_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            tag_q       <= tag_d;
            set_q       <= set_d;
            victim_q    <= victim_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        issue_cnt_d     = issue_cnt_q;
        ret_cnt_d       = ret_cnt_q;
        tag_d           = tag_q;
        set_d           = set_q;
        victim_d        = victim_q;

        bus.stall       = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_addr    = '0;
        bus.write_en_0  = 1'b0;
        bus.write_en_1  = 1'b0;
        bus.cache_data  = '0;
        bus.cache_word  = '0;
        bus.cache_block = '0;
        bus.cache_tag   = '0;
        bus.fill_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.stall   = bus.miss_detected;
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                if (bus.miss_detected) begin
                    tag_d    = bus.miss_address[TAG_HI:TAG_LO];
                    set_d    = bus.miss_address[SET_HI:SET_LO];
                    victim_d = bus.victim_way;
                    state_d  = FILL;
                end
            end

            FILL: begin
                bus.stall = 1'b1;
                // Issue and return counters run independently; memory keeps returns in order.
                if (issue_cnt_q < CNT_W'(WORDS)) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {tag_q, set_q, issue_cnt_q[WORD_W-1:0], 1'b0};
                    issue_cnt_d  = issue_cnt_q + CNT_W'(1);
                end
                if (bus.mem_data_valid && (ret_cnt_q < CNT_W'(WORDS))) begin
                    bus.write_en_0  = ~victim_q;
                    bus.write_en_1  = victim_q;
                    bus.cache_data  = bus.mem_data;
                    bus.cache_word  = word_oh;
                    bus.cache_block = set_oh;
                    bus.cache_tag   = fill_meta(tag_q);
                    ret_cnt_d       = ret_cnt_q + CNT_W'(1);
                    if (ret_cnt_q == CNT_W'(WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                bus.stall     = 1'b1;
                bus.fill_done = 1'b1;
                issue_cnt_d   = '0;
                ret_cnt_d     = '0;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Self-checking bench for dcache_fill_fsm: directed vector table, hand sequences, randomized run.
module tb_dcache_fill_fsm;

    localparam int MEM_LAT = int'(dcache_pkg::MEM_LAT);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_fill_fsm_if bus ();

    dcache_fill_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;
    rd_t         rdq[$];
    logic [15:0] mem_arr [0:32767];

    // Reference model: a fill is "busy" from acceptance until the cycle after 8 returns.
    bit          m_busy = 1'b0;
    int          m_issued = 0;
    int          m_returned = 0;
    logic [5:0]  m_tag = '0;
    logic [5:0]  m_set = '0;
    logic        m_vic = 1'b0;

    int          o_we0, o_we1, o_memen, o_stall, o_done_cyc, o_nw;
    bit          o_first_seen;
    logic [15:0] o_first_addr, o_last_addr, o_first_data, o_last_data;
    logic [7:0]  o_word_or, o_tag_last;
    logic [63:0] o_block_or;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic obs_clear();
        o_we0 = 0; o_we1 = 0; o_memen = 0; o_stall = 0; o_done_cyc = -1; o_nw = 0;
        o_first_seen = 1'b0;
        o_first_addr = '0; o_last_addr = '0; o_first_data = '0; o_last_data = '0;
        o_word_or = '0; o_tag_last = '0; o_block_or = '0;
    endtask

    task automatic step(input bit r, input bit m, input logic [15:0] a, input bit v,
                        input bit sp, input logic [15:0] sd);
        bit          done_e, fill_e, memen_e, wr_e;
        logic [15:0] base;
        @(negedge clk);
        cyc++;
        rst                = r;
        bus.miss_detected  = m;
        bus.miss_address   = a;
        bus.victim_way     = v;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = mem_arr[rdq[0].addr[15:1]];
            void'(rdq.pop_front());
        end else if (sp) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data       = sd;
        end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data       = 16'($urandom);
        end
        #1;
        done_e  = m_busy && (m_returned == 8);
        fill_e  = m_busy && !done_e;
        memen_e = fill_e && (m_issued < 8);
        wr_e    = fill_e && bus.mem_data_valid;
        base    = {m_tag, m_set, 4'b0000};

        chk("stall",       64'(bus.stall),       64'(m_busy ? 1'b1 : bus.miss_detected));
        chk("mem_en",      64'(bus.mem_en),      64'(memen_e));
        chk("mem_addr",    64'(bus.mem_addr),    memen_e ? 64'(base + 16'(2 * m_issued)) : 64'd0);
        chk("write_en_0",  64'(bus.write_en_0),  64'(wr_e && !m_vic));
        chk("write_en_1",  64'(bus.write_en_1),  64'(wr_e && m_vic));
        chk("we_exclusive", 64'(bus.write_en_0 & bus.write_en_1), 64'd0);
        chk("cache_data",  64'(bus.cache_data),  wr_e ? 64'(bus.mem_data) : 64'd0);
        chk("cache_word",  64'(bus.cache_word),  wr_e ? (64'd1 << m_returned) : 64'd0);
        chk("cache_block", bus.cache_block,      wr_e ? (64'd1 << m_set) : 64'd0);
        chk("cache_tag",   64'(bus.cache_tag),   wr_e ? 64'({2'b11, m_tag}) : 64'd0);
        chk("fill_done",   64'(bus.fill_done),   64'(done_e));

        if (bus.mem_en) begin
            if (!o_first_seen) o_first_addr = bus.mem_addr;
            o_first_seen = 1'b1;
            o_last_addr  = bus.mem_addr;
            o_memen++;
            rdq.push_back('{addr: bus.mem_addr, due: cyc + MEM_LAT});
        end
        if (bus.write_en_0 || bus.write_en_1) begin
            if (o_nw == 0) o_first_data = bus.cache_data;
            o_last_data = bus.cache_data;
            o_nw++;
            o_word_or  |= bus.cache_word;
            o_block_or |= bus.cache_block;
            o_tag_last  = bus.cache_tag;
        end
        o_we0   += int'(bus.write_en_0);
        o_we1   += int'(bus.write_en_1);
        o_stall += int'(bus.stall);
        if (bus.fill_done) o_done_cyc = cyc;

        if (r || done_e) begin
            m_busy = 1'b0; m_issued = 0; m_returned = 0;
        end else if (m_busy) begin
            if (m_issued < 8) m_issued++;
            if (bus.mem_data_valid) m_returned++;
        end else if (bus.miss_detected) begin
            m_busy = 1'b1;
            m_tag  = bus.miss_address[15:10];
            m_set  = bus.miss_address[9:4];
            m_vic  = bus.victim_way;
        end
    endtask

    int done_rel;

    // Drives one miss until fill_done, then drops miss_detected for one cycle.
    task automatic run_fill(input logic [15:0] a, input bit v, input int chg_k);
        int c0;
        bit seen;
        obs_clear();
        c0   = cyc + 1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1'b0, 1'b1, (chg_k >= 0 && k >= chg_k) ? 16'h1234 : a, v, 1'b0, 16'h0);
            if (bus.fill_done) seen = 1'b1;
        end
        chk("fill_done_seen", 64'(seen), 64'd1);
        done_rel = o_done_cyc - c0;
        step(1'b0, 1'b0, a, v, 1'b0, 16'h0);
        chk("resume_stall", 64'(bus.stall), 64'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        bit          vic;
        int          chg_k;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        logic [63:0] exp_block;
        logic [7:0]  exp_tag;
        int          exp_we0;
        int          exp_we1;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit          want;
        logic [15:0] ma;
        bit          mv;

        tbl[0] = '{16'h2A36, 1'b0, -1, 16'h2A30, 16'h2A3E, 64'h0000_0008_0000_0000, 8'hCA, 8, 0};
        tbl[1] = '{16'h2A36, 1'b1, -1, 16'h2A30, 16'h2A3E, 64'h0000_0008_0000_0000, 8'hCA, 0, 8};
        tbl[2] = '{16'h0000, 1'b0, -1, 16'h0000, 16'h000E, 64'h0000_0000_0000_0001, 8'hC0, 8, 0};
        tbl[3] = '{16'hFFF0, 1'b1, -1, 16'hFFF0, 16'hFFFE, 64'h8000_0000_0000_0000, 8'hFF, 0, 8};
        tbl[4] = '{16'h2A36, 1'b0,  3, 16'h2A30, 16'h2A3E, 64'h0000_0008_0000_0000, 8'hCA, 8, 0};

        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'h1000 + 16'(i % 8);

        rst = 1'b1;
        bus.miss_detected = 1'b0; bus.miss_address = '0; bus.victim_way = 1'b0;
        bus.mem_data_valid = 1'b0; bus.mem_data = '0;

        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("reset_stall",    64'(bus.stall),    64'd0);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("reset_block",    bus.cache_block,   64'd0);

        // Directed fills: latency, addresses, way selection and metadata per row.
        for (int i = 0; i < 5; i++) begin
            run_fill(tbl[i].addr, tbl[i].vic, tbl[i].chg_k);
            chk("first_mem_addr", 64'(o_first_addr), 64'(tbl[i].exp_first));
            chk("last_mem_addr",  64'(o_last_addr),  64'(tbl[i].exp_last));
            chk("mem_reads",      64'(o_memen),      64'd8);
            chk("block_written",  o_block_or,        tbl[i].exp_block);
            chk("tag_written",    64'(o_tag_last),   64'(tbl[i].exp_tag));
            chk("words_written",  64'(o_word_or),    64'hFF);
            chk("we0_count",      64'(o_we0),        64'(tbl[i].exp_we0));
            chk("we1_count",      64'(o_we1),        64'(tbl[i].exp_we1));
            chk("first_data",     64'(o_first_data), 64'h1000);
            chk("last_data",      64'(o_last_data),  64'h1007);
            chk("done_cycle",     64'(done_rel),     64'd13);
            chk("stall_cycles",   64'(o_stall),      64'd14);
        end

        // Reset at cycle 6 of a fill: no further reads or writes afterwards.
        obs_clear();
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 16'h2A36, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h2A36, 1'b0, 1'b0, 16'h0);
        obs_clear();
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 16'h2A36, 1'b0, 1'b0, 16'h0);
        chk("rst_writes", 64'(o_we0 + o_we1), 64'd0);
        chk("rst_reads",  64'(o_memen),       64'd0);
        chk("rst_stall",  64'(o_stall),       64'd0);

        // Spurious return while idle.
        obs_clear();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("spur_writes", 64'(o_we0 + o_we1), 64'd0);
        chk("spur_stall",  64'(o_stall),       64'd0);

        // Randomized traffic: resets, held misses, address churn and idle noise.
        for (int i = 0; i < 32768; i++) mem_arr[i] = 16'($urandom);
        want = 1'b0;
        ma   = '0;
        mv   = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            bit r;
            bit sp;
            r = ($urandom_range(0, 299) == 0);
            if (!want && $urandom_range(0, 3) == 0) begin
                want = 1'b1;
                ma   = 16'($urandom);
                mv   = 1'($urandom);
            end
            sp = (!m_busy || m_returned == 8) && ($urandom_range(0, 5) == 0);
            step(r, want,
                 ($urandom_range(0, 3) == 0) ? 16'($urandom) : ma,
                 ($urandom_range(0, 3) == 0) ? 1'($urandom) : mv,
                 sp, 16'($urandom));
            if (bus.fill_done) want = ($urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("final_idle_stall", 64'(bus.stall), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
